// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and the control-port arbiter state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } arb_state_e;

endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NUM_REQ.
module axi4_lite_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index
);

  logic [IW:0] cand_s;
  logic [IW:0] wrap_s;
  logic        hit_s;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant  = '0;
    index  = '0;
    cand_s = '0;
    wrap_s = '0;
    hit_s  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_s = {1'b0, ptr} + (IW + 1)'(i);
      wrap_s = (cand_s >= (IW + 1)'(NUM_REQ)) ? (cand_s - (IW + 1)'(NUM_REQ)) : cand_s;
      hit_s  = req[wrap_s[IW-1:0]];
      grant  = hit_s ? (NUM_REQ'(1) << wrap_s[IW-1:0]) : grant;
      index  = hit_s ? wrap_s[IW-1:0] : index;
    end
  end

endmodule

// File: rtl/axi4_lite_ctrl_arbiter.sv
// Round-robin sharing of one AXI4-Lite master control port between NUM_REQ requesters.
// Optional WAIT timeout with DRAIN recovery is enabled by defining ARB_TIMEOUT_EN.
module axi4_lite_ctrl_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic [ADDRESS_WIDTH-1:0]            ctrl_addr,
  output logic [DATA_WIDTH-1:0]               ctrl_wdata,
  output logic [DATA_WIDTH/8-1:0]             ctrl_wstrb,
  output logic                                ctrl_write_req,
  output logic                                ctrl_read_req,
  input  logic [DATA_WIDTH-1:0]               ctrl_rdata,
  input  logic                                ctrl_write_done,
  input  logic                                ctrl_read_done,
  input  logic [1:0]                          ctrl_resp,
  output logic                                busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;

  arb_state_e               state_r;
  arb_state_e               next_state_s;
  logic [IW-1:0]            ptr_r;
  logic [IW-1:0]            arb_idx_s;
  logic [NUM_REQ-1:0]       arb_grant_s;
  logic [NUM_REQ-1:0]       grant_r;
  logic                     arb_any_s;
  logic                     grant_load_s;
  logic                     op_write_r;
  logic                     done_match_s;
  logic                     done_hit_s;
  logic                     timeout_hit_s;
  logic [NUM_REQ-1:0]       req_ready_r;
  logic [NUM_REQ-1:0]       rsp_valid_r;
  logic [DATA_WIDTH-1:0]    rsp_rdata_r;
  logic [1:0]               rsp_resp_r;
  logic [ADDRESS_WIDTH-1:0] ctrl_addr_r;
  logic [DATA_WIDTH-1:0]    ctrl_wdata_r;
  logic [SW-1:0]            ctrl_wstrb_r;
  logic                     ctrl_write_req_r;
  logic                     ctrl_read_req_r;
  logic                     busy_r;

  axi4_lite_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (arb_grant_s),
    .index (arb_idx_s)
  );

  assign arb_any_s    = |req_valid;
  assign grant_load_s = (state_r == IDLE) && arb_any_s;
  // A done pulse of the other operation type never ends WAIT.
  assign done_match_s = op_write_r ? ctrl_write_done : ctrl_read_done;
  assign done_hit_s   = (state_r == WAIT) && done_match_s;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;

  // Counts consecutive WAIT cycles; cleared in every other state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r == WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= 16'd0;
    end
  end

  assign timeout_hit_s = (state_r == WAIT) && !done_match_s &&
                         (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (arb_any_s) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: next_state_s = WAIT;
      WAIT: begin
        if (done_match_s) begin
          next_state_s = RESP;
        end else if (timeout_hit_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: next_state_s = IDLE;
`ifdef ARB_TIMEOUT_EN
      DRAIN: begin
        if (ctrl_write_done || ctrl_read_done) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DRAIN;
        end
      end
`endif
      default: next_state_s = IDLE;
    endcase
  end

  // Grant latching, pointer advance and all registered outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ptr_r            <= '0;
      grant_r          <= '0;
      op_write_r       <= 1'b0;
      req_ready_r      <= '0;
      rsp_valid_r      <= '0;
      rsp_rdata_r      <= '0;
      rsp_resp_r       <= RESP_OKAY;
      ctrl_addr_r      <= '0;
      ctrl_wdata_r     <= '0;
      ctrl_wstrb_r     <= '0;
      ctrl_write_req_r <= 1'b0;
      ctrl_read_req_r  <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      req_ready_r      <= grant_load_s ? arb_grant_s : '0;
      ctrl_write_req_r <= grant_load_s && req_write[arb_idx_s];
      ctrl_read_req_r  <= grant_load_s && !req_write[arb_idx_s];
      busy_r           <= (next_state_s != IDLE);
      if (grant_load_s) begin
        grant_r      <= arb_grant_s;
        op_write_r   <= req_write[arb_idx_s];
        ctrl_addr_r  <= req_addr[int'(arb_idx_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        ctrl_wdata_r <= req_wdata[int'(arb_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        ctrl_wstrb_r <= req_wstrb[int'(arb_idx_s)*SW +: SW];
        ptr_r        <= (arb_idx_s == IW'(NUM_REQ - 1)) ? '0 : (arb_idx_s + IW'(1));
      end
      if (done_hit_s) begin
        rsp_valid_r <= grant_r;
        rsp_rdata_r <= op_write_r ? '0 : ctrl_rdata;
        rsp_resp_r  <= ctrl_resp;
      end else if (timeout_hit_s) begin
        rsp_valid_r <= grant_r;
        rsp_rdata_r <= '0;
        rsp_resp_r  <= RESP_SLVERR;
      end else begin
        rsp_valid_r <= '0;
        rsp_rdata_r <= '0;
        rsp_resp_r  <= RESP_OKAY;
      end
    end
  end

  assign req_ready      = req_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign rsp_resp       = rsp_resp_r;
  assign ctrl_addr      = ctrl_addr_r;
  assign ctrl_wdata     = ctrl_wdata_r;
  assign ctrl_wstrb     = ctrl_wstrb_r;
  assign ctrl_write_req = ctrl_write_req_r;
  assign ctrl_read_req  = ctrl_read_req_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_axi4_lite_ctrl_arbiter.sv
// Scoreboard bench for axi4_lite_ctrl_arbiter with a behavioural master model.
module tb_axi4_lite_ctrl_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [AW-1:0]   ctrl_addr;
  logic [DW-1:0]   ctrl_wdata;
  logic [SW-1:0]   ctrl_wstrb;
  logic            ctrl_write_req;
  logic            ctrl_read_req;
  logic [DW-1:0]   ctrl_rdata;
  logic            ctrl_write_done;
  logic            ctrl_read_done;
  logic [1:0]      ctrl_resp;
  logic            busy;

  axi4_lite_ctrl_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_wstrb(ctrl_wstrb),
    .ctrl_write_req(ctrl_write_req), .ctrl_read_req(ctrl_read_req),
    .ctrl_rdata(ctrl_rdata), .ctrl_write_done(ctrl_write_done),
    .ctrl_read_done(ctrl_read_done), .ctrl_resp(ctrl_resp), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [N-1:0]  who;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } ctl_t;

  rsp_t         exp_rsp[$];
  ctl_t         exp_ctl[$];
  logic [N-1:0] exp_gnt[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  // Master model knobs.
  logic          mdl_mute  = 1'b0;
  logic          mdl_stray = 1'b0;
  int            mdl_lat   = 1;
  logic [DW-1:0] mdl_rdata = '0;
  logic [1:0]    mdl_resp  = 2'b00;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {15'd0, req_ready, rsp_valid, rsp_rdata, rsp_resp, ctrl_addr, ctrl_wdata,
            ctrl_wstrb, ctrl_write_req, ctrl_read_req, busy};
  endfunction

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
    req_write[idx]            = wr;
    req_addr[idx*AW +: AW]    = addr;
    req_wdata[idx*DW +: DW]   = wdata;
    req_wstrb[idx*SW +: SW]   = wstrb;
  endtask

  task automatic push_exp(input int idx, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                          input logic with_rsp, input logic [DW-1:0] rdata, input logic [1:0] resp);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_gnt.push_back(oh);
    exp_ctl.push_back({wr, ~wr, addr, wdata, wstrb});
    if (with_rsp) exp_rsp.push_back({oh, rdata, resp});
  endtask

  task automatic request(input int idx, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
    int k;
    set_req(idx, wr, addr, wdata, wstrb);
    req_valid[idx] = 1'b1;
    k = 0;
    while (!req_ready[idx] && k < 50) begin
      @(negedge ACLK);
      k++;
    end
    if (k >= 50) check("ready_timeout", 128'(k), 128'd0);
    req_valid[idx] = 1'b0;
  endtask

  task automatic burst(input logic [N-1:0] mask, input int ngr, input logic drop);
    int got;
    int k;
    got = 0;
    k = 0;
    req_valid = mask;
    while (got < ngr && k < 300) begin
      @(negedge ACLK);
      k++;
      if (req_ready != '0) begin
        got++;
        if (got == ngr) req_valid = '0;
        else if (drop) req_valid = req_valid & ~req_ready;
      end
    end
    req_valid = '0;
    if (got < ngr) check("burst_grants", 128'(got), 128'(ngr));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge ACLK);
      k++;
    end while ((busy || exp_rsp.size() != 0) && k < 300);
    if (k >= 300) check("idle_timeout", 128'(k), 128'd0);
  endtask

  // Monitors: compare every grant, master request and response against the queues.
  initial begin
    rsp_t         er;
    ctl_t         ec;
    logic [N-1:0] eg;
    forever begin
      @(negedge ACLK);
      if (req_ready != '0) begin
        if (exp_gnt.size() == 0) check("ready_unexpected", 128'(req_ready), 128'd0);
        else begin
          eg = exp_gnt.pop_front();
          check("ready_grant", 128'(req_ready), 128'(eg));
        end
      end
      if (ctrl_write_req || ctrl_read_req) begin
        if (exp_ctl.size() == 0) check("ctrl_unexpected", 128'({ctrl_write_req, ctrl_read_req}), 128'd0);
        else begin
          ec = exp_ctl.pop_front();
          check("ctrl_issue", 128'({ctrl_write_req, ctrl_read_req, ctrl_addr, ctrl_wdata, ctrl_wstrb}),
                128'(ec));
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 128'(rsp_valid), 128'd0);
        else begin
          er = exp_rsp.pop_front();
          check("rsp", 128'({rsp_valid, rsp_rdata, rsp_resp}), 128'(er));
        end
      end
    end
  end

  // Master model: answers each request after mdl_lat cycles, optionally with a stray write_done.
  initial begin
    logic wr;
    ctrl_write_done = 1'b0;
    ctrl_read_done  = 1'b0;
    ctrl_rdata      = '0;
    ctrl_resp       = 2'b00;
    forever begin
      @(negedge ACLK);
      if (ARESETn && (ctrl_write_req || ctrl_read_req) && !mdl_mute) begin
        wr = ctrl_write_req;
        if (mdl_stray && !wr) begin
          @(negedge ACLK);
          ctrl_write_done = 1'b1;
          ctrl_rdata      = 32'h0BAD_0BAD;
          @(negedge ACLK);
          ctrl_write_done = 1'b0;
        end
        repeat (mdl_lat) @(negedge ACLK);
        ctrl_rdata = wr ? 32'h0BAD_0BAD : mdl_rdata;
        ctrl_resp  = mdl_resp;
        if (wr) ctrl_write_done = 1'b1;
        else    ctrl_read_done  = 1'b1;
        @(negedge ACLK);
        ctrl_write_done = 1'b0;
        ctrl_read_done  = 1'b0;
        ctrl_rdata      = 32'h1357_9BDF;
        ctrl_resp       = 2'b01;
      end
    end
  end

  initial begin
    int t_rsp;
    int t_idle;
    // Reset state.
    #1;
    check("reset_outputs", all_outs(), 128'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Single write from requester 2.
    mdl_lat = 2; mdl_resp = 2'b00;
    push_exp(2, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 2'b00);
    request(2, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_idle();

    // Single read from requester 0.
    mdl_lat = 1; mdl_rdata = 32'hCAFE_F00D;
    push_exp(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 2'b00);
    request(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    wait_idle();

    // DECERR read with a stray write_done during WAIT.
    mdl_stray = 1'b1; mdl_resp = 2'b11; mdl_rdata = 32'h1234_5678;
    push_exp(3, 1'b0, 32'h0000_0F00, 32'hFFFF_FFFF, 4'h3, 1'b1, 32'h1234_5678, 2'b11);
    request(3, 1'b0, 32'h0000_0F00, 32'hFFFF_FFFF, 4'h3);
    wait_idle();
    mdl_stray = 1'b0;

    // All four held from reset: grant order 0,1,2,3,0.
    @(negedge ACLK);
    ARESETn = 1'b0;
    mdl_resp = 2'b01; mdl_rdata = 32'h0A0A_0A0A; mdl_lat = 1;
    for (int i = 0; i < N; i++) set_req(i, i[0], 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1));
    for (int j = 0; j < 5; j++) begin
      push_exp(j % N, (j % N) % 2 == 1, 32'h100 + 32'((j % N) * 4), 32'hA000_0000 + 32'(j % N),
               4'((j % N) + 1), 1'b1, ((j % N) % 2 == 1) ? 32'h0 : 32'h0A0A_0A0A, 2'b01);
    end
    req_valid = 4'hF;
    @(negedge ACLK);
    ARESETn = 1'b1;
    burst(4'hF, 5, 1'b0);
    wait_idle();

    // Reset asserted in WAIT drops the transaction silently.
    mdl_mute = 1'b1;
    push_exp(1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
    request(1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    repeat (3) @(negedge ACLK);
    check("busy_in_wait", 128'(busy), 128'd1);
    #2 ARESETn = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 128'd0);
    @(negedge ACLK);
    ARESETn  = 1'b1;
    mdl_mute = 1'b0;
    repeat (8) @(negedge ACLK);
    check("idle_after_reset", 128'(busy), 128'd0);

    // Pointer is 0 after reset: requesters 3 and 1 together are served 1 then 3.
    mdl_resp = 2'b00; mdl_rdata = 32'h7777_0003;
    set_req(1, 1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hC);
    set_req(3, 1'b0, 32'h0000_0308, 32'h0, 4'h1);
    push_exp(1, 1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hC, 1'b1, 32'h0, 2'b00);
    push_exp(3, 1'b0, 32'h0000_0308, 32'h0, 4'h1, 1'b1, 32'h7777_0003, 2'b00);
    burst(4'b1010, 2, 1'b1);
    wait_idle();

    // A request withdrawn before IDLE is never granted.
    mdl_lat = 6; mdl_rdata = 32'h0000_BEEF;
    push_exp(0, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 1'b1, 32'h0000_BEEF, 2'b00);
    request(0, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    set_req(2, 1'b1, 32'h0000_0500, 32'h1, 4'h1);
    req_valid[2] = 1'b1;
    repeat (2) @(negedge ACLK);
    req_valid[2] = 1'b0;
    wait_idle();

`ifdef ARB_TIMEOUT_EN
    // Silent master: SLVERR after 16 WAIT cycles, busy held in DRAIN until the late done.
    mdl_lat = 25;
    push_exp(2, 1'b0, 32'h0000_0600, 32'h0, 4'h0, 1'b1, 32'h0, 2'b10);
    request(2, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
    t_rsp = 0;
    t_idle = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge ACLK);
      if (rsp_valid != '0 && t_rsp == 0) t_rsp = k;
      if (k == 20) check("busy_in_drain", 128'(busy), 128'd1);
      if (!busy && t_idle == 0) t_idle = k;
    end
    check("timeout_cycle", 128'(t_rsp), 128'd17);
    check("drain_release", 128'(t_idle), 128'd26);
    mdl_lat = 1; mdl_rdata = 32'h600D_600D;
    push_exp(1, 1'b0, 32'h0000_0700, 32'h0, 4'h0, 1'b1, 32'h600D_600D, 2'b00);
    request(1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    wait_idle();
`else
    t_rsp = 0;
    t_idle = 0;
`endif

    repeat (4) @(negedge ACLK);
    check("rsp_queue_drained", 128'(exp_rsp.size()), 128'(t_rsp * 0));
    check("ctl_queue_drained", 128'(exp_ctl.size()), 128'(t_idle * 0));
    check("gnt_queue_drained", 128'(exp_gnt.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
